q_8_41_controller: RTL and testbench

//   Control FSM for the Q8.41 decimate-by-2 datapath. Sequences sample capture into
//   the P1/P0 pair register, then commits one result per two samples into R0.

---
 rtl/q_8_41_pkg.sv | 11 +
 rtl/q_8_41_controller.sv | 77 +++++++
 tb/tb_q_8_41_controller.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/q_8_41_pkg.sv
// Shared types for the Q8.41 decimate-by-2 controller.
package q_8_41_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_FIRST  = 2'b01,
        S_SECOND = 2'b10,
        S_OUT    = 2'b11
    } state_t;

endpackage

// File: rtl/q_8_41_controller.sv
// Control FSM for the Q8.41 decimate-by-2 datapath: drives the P1/P0 pair
// register clear/shift enables and the one-per-pair R0 commit strobe.
module q_8_41_controller
    import q_8_41_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    output logic clr_P1_P0,
    output logic load_P1_P0,
    output logic load_R0
);

    state_t state;
    state_t next_state_s;

    // State register; reset lands in S_IDLE without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state_s;
        end
    end

    // Next-state and output decode; en=0 always wins over load.
    always_comb begin
        next_state_s = S_IDLE;
        clr_P1_P0    = 1'b0;
        load_P1_P0   = 1'b0;
        load_R0      = 1'b0;
        case (state)
            S_IDLE: begin
                clr_P1_P0 = 1'b1;
                if (en) begin
                    next_state_s = S_FIRST;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_FIRST: begin
                load_P1_P0 = en & load;
                if (!en) begin
                    next_state_s = S_IDLE;
                end else if (load) begin
                    next_state_s = S_SECOND;
                end else begin
                    next_state_s = S_FIRST;
                end
            end
            S_SECOND: begin
                load_P1_P0 = en & load;
                if (!en) begin
                    next_state_s = S_IDLE;
                end else if (load) begin
                    next_state_s = S_OUT;
                end else begin
                    next_state_s = S_SECOND;
                end
            end
            S_OUT: begin
                load_R0 = 1'b1;
                if (en) begin
                    next_state_s = S_FIRST;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            default: begin
                clr_P1_P0    = 1'b1;
                next_state_s = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_q_8_41_controller.sv
// Directed self-checking bench for q_8_41_controller.
module tb_q_8_41_controller;

    logic clk;
    logic rst;
    logic en;
    logic load;
    logic clr_P1_P0;
    logic load_P1_P0;
    logic load_R0;

    int n_checks;
    int n_errors;

    q_8_41_controller dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .clr_P1_P0  (clr_P1_P0),
        .load_P1_P0 (load_P1_P0),
        .load_R0    (load_R0)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_checks = n_checks + 1;
        if (obs !== exp_v) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check state plus all three outputs in one call.
    task automatic check_all(input string tag, input logic [1:0] st,
                             input logic clr, input logic lp, input logic r0);
        check({tag, ".state"}, {2'b00, dut.state}, {2'b00, st});
        check({tag, ".clr"},   {3'b000, clr_P1_P0},  {3'b000, clr});
        check({tag, ".lp"},    {3'b000, load_P1_P0}, {3'b000, lp});
        check({tag, ".r0"},    {3'b000, load_R0},    {3'b000, r0});
    endtask

    logic [1:0] exp_st [6];
    logic       exp_lp [6];
    logic       exp_r0 [6];
    int         r0_count;

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_st = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01};
        exp_lp = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
        exp_r0 = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};

        // 1: reset applies before any clock edge
        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        #3;
        check_all("rst_async", 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_all("idle_hold", 2'b00, 1'b1, 1'b0, 1'b0);
        end

        // 2: en=1, load=0 -> parked in S_FIRST
        en = 1'b1;
        #1;
        check_all("idle_en", 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("first_wait", 2'b01, 1'b0, 1'b0, 1'b0);
        end

        // 3: held load -> 01,10,11,01,10,11,01
        load = 1'b1;
        #1;
        check_all("load_first", 2'b01, 1'b0, 1'b1, 1'b0);
        r0_count = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_all("stream", exp_st[i], 1'b0, exp_lp[i], exp_r0[i]);
            if (load_R0) r0_count = r0_count + 1;
        end
        check("r0_count", r0_count[3:0], 4'd2);

        // 4: drop en in S_SECOND with load=1
        tick();
        check_all("pre_abort", 2'b10, 1'b0, 1'b1, 1'b0);
        en = 1'b0;
        #1;
        check_all("abort_mealy", 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("abort_idle", 2'b00, 1'b1, 1'b0, 1'b0);

        // 5: restore from IDLE; load_R0 three edges after en rises
        en = 1'b1;
        #1;
        check_all("restart_idle", 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("restart_e1", 2'b01, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("restart_e2", 2'b10, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("restart_e3", 2'b11, 1'b0, 1'b0, 1'b1);
        tick();
        check_all("restart_e4", 2'b01, 1'b0, 1'b1, 1'b0);

        // 6: async reset between edges while in S_SECOND
        tick();
        check_all("pre_rst", 2'b10, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all("rst_mid", 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("rst_held", 2'b00, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        en  = 1'b0;
        tick();
        check_all("rst_release", 2'b00, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
